ncsp_mash_seq: RTL

- Configuration sequencer placed in front of the NCSP MASH top.
- Accepts a complete new operating point over a valid/ready handshake: integer word, MSB/ISB/LSB fractional words, seed, order, MASH bit width, fractional-select and phase step.
- Applies the operating point in a fixed, glitch-free order: optional MASH reset and reseed, frequency-word update, pipeline settle, optional phase-adjust pulse, done pulse.
- Guarantees the DDSM never sees a half-updated configuration.

---
 rtl/ncsp_pkg.sv | 35 +++
 rtl/ncsp_seq_cfg_reg.sv | 23 ++
 rtl/ncsp_mash_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ncsp_pkg.sv
// ncsp_pkg: shared types and widths for the NCSP MASH configuration sequencer.
//   seq_state_e : sequencer states
//   cfg_t       : one complete operating point (words, MASH config, reseed flag, phase step)
package ncsp_pkg;

   localparam int unsigned INT_W   = 8;
   localparam int unsigned FRAC_W  = 8;
   localparam int unsigned SEED_W  = 12;
   localparam int unsigned PHASE_W = 12;
   localparam int unsigned ORDER_W = 2;
   localparam int unsigned MBIT_W  = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RESET  = 3'd1,
      ST_APPLY  = 3'd2,
      ST_SETTLE = 3'd3,
      ST_PHASE  = 3'd4,
      ST_DONE   = 3'd5
   } seq_state_e;

   typedef struct packed {
      logic [INT_W-1:0]   int_word;
      logic [FRAC_W-1:0]  msb;
      logic [FRAC_W-1:0]  isb;
      logic [FRAC_W-1:0]  lsb;
      logic [SEED_W-1:0]  seed;
      logic [ORDER_W-1:0] sel_order;
      logic [MBIT_W-1:0]  mash_bit;
      logic               sel_frac;
      logic               reseed;
      logic [PHASE_W-1:0] phaseadd;
   } cfg_t;

endpackage

// File: rtl/ncsp_seq_cfg_reg.sv
// ncsp_seq_cfg_reg: load-enabled register for one cfg_t operating point, async clear.
//   i_clk, i_rst_n : clock, async active-low clear
//   i_load         : capture i_d on the rising edge
//   i_d / o_q      : operating point in / held operating point out
module ncsp_seq_cfg_reg
   import ncsp_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_load,
   input  cfg_t i_d,
   output cfg_t o_q
);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_q <= '0;
      end else if (i_load) begin
         o_q <= i_d;
      end
   end

endmodule

// File: rtl/ncsp_mash_seq.sv
// ncsp_mash_seq: configuration sequencer in front of the NCSP MASH top.
// Takes a full operating point over valid/ready and applies it in a fixed order:
// optional MASH reset/reseed, frequency-word update, pipeline settle, optional
// phase-adjust pulse, done pulse. Every output is registered.
//   i_valid/o_ready     : request handshake
//   i_int..i_phaseadd   : requested operating point
//   o_int..o_sel_frac   : applied operating point
//   o_mashreseten       : MASH reset enable, RST_CYCLES long on reseed requests
//   o_phaseadjusten/o_phaseadd : one-cycle phase step
//   o_busy, o_done      : sequence in progress / one-cycle completion
// Build option: define NCSP_SEQ_QUEUE_EN for a one-entry pending request buffer.
module ncsp_mash_seq
   import ncsp_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = 4,
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter int unsigned CNT_W         = 8
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [INT_W-1:0]   i_int,
   input  logic [FRAC_W-1:0]  i_msb,
   input  logic [FRAC_W-1:0]  i_isb,
   input  logic [FRAC_W-1:0]  i_lsb,
   input  logic [SEED_W-1:0]  i_seed,
   input  logic [ORDER_W-1:0] i_sel_order,
   input  logic [MBIT_W-1:0]  i_mash_bit,
   input  logic               i_sel_frac,
   input  logic               i_reseed,
   input  logic [PHASE_W-1:0] i_phaseadd,
   output logic [INT_W-1:0]   o_int,
   output logic [FRAC_W-1:0]  o_msb,
   output logic [FRAC_W-1:0]  o_isb,
   output logic [FRAC_W-1:0]  o_lsb,
   output logic [SEED_W-1:0]  o_seed,
   output logic [ORDER_W-1:0] o_sel_order,
   output logic [MBIT_W-1:0]  o_mash_bit,
   output logic               o_sel_frac,
   output logic               o_mashreseten,
   output logic               o_phaseadjusten,
   output logic [PHASE_W-1:0] o_phaseadd,
   output logic               o_busy,
   output logic               o_done
);

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   seq_state_e       state;
   seq_state_e       state_n;
   seq_state_e       after_settle;
   logic [CNT_W-1:0] cnt;
   cfg_t             req;
   cfg_t             shadow;
   cfg_t             start_cfg;
   logic             accept;
   logic             start;
   logic             ready_n;

   assign req = '{int_word:  i_int,
                  msb:       i_msb,
                  isb:       i_isb,
                  lsb:       i_lsb,
                  seed:      i_seed,
                  sel_order: i_sel_order,
                  mash_bit:  i_mash_bit,
                  sel_frac:  i_sel_frac,
                  reseed:    i_reseed,
                  phaseadd:  i_phaseadd};

`ifdef NCSP_SEQ_QUEUE_EN
   cfg_t pend;
   logic pend_full;
   logic pend_full_n;
   logic pend_load;
`endif

   // Next state, launch of a new operating point, and next ready
   always_comb begin
      accept       = i_valid & o_ready;
      start        = 1'b0;
      start_cfg    = req;
      state_n      = state;
      after_settle = (shadow.phaseadd != '0) ? ST_PHASE : ST_DONE;
`ifdef NCSP_SEQ_QUEUE_EN
      pend_load    = 1'b0;
      pend_full_n  = pend_full;
`endif
      case (state)
         ST_IDLE:   start = accept;
         ST_RESET:  if (cnt == RST_LAST) state_n = ST_APPLY;
         ST_APPLY:  state_n = (SETTLE_CYCLES == 0) ? after_settle : ST_SETTLE;
         ST_SETTLE: if (cnt == SETTLE_LAST) state_n = after_settle;
         ST_PHASE:  state_n = ST_DONE;
         ST_DONE: begin
            state_n = ST_IDLE;
`ifdef NCSP_SEQ_QUEUE_EN
            // A waiting entry wins; a request arriving now refills the freed slot
            if (pend_full) begin
               start     = 1'b1;
               start_cfg = pend;
               pend_load = accept;
            end else begin
               start     = accept;
            end
`endif
         end
         default:   state_n = ST_IDLE;
      endcase

      if (start) state_n = start_cfg.reseed ? ST_RESET : ST_APPLY;

`ifdef NCSP_SEQ_QUEUE_EN
      if (accept && (state != ST_IDLE) && (state != ST_DONE)) pend_load = 1'b1;
      pend_full_n = pend_load | (pend_full & (state != ST_DONE));
      // The DONE cycle may accept even with a full slot, since that slot drains on exit
      ready_n     = ~pend_full_n | (state_n == ST_DONE);
`else
      ready_n     = (state_n == ST_IDLE);
`endif
   end

   // State register and per-state cycle counter (cleared on every state entry)
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= ((state_n != state) || (state_n == ST_IDLE)) ? '0 : cnt + CNT_W'(1);
      end
   end

   // Registered outputs; strobes decode the registered state so they never glitch
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_ready         <= 1'b1;
         o_busy          <= 1'b0;
         o_done          <= 1'b0;
         o_mashreseten   <= 1'b0;
         o_phaseadjusten <= 1'b0;
         o_phaseadd      <= '0;
         o_int           <= '0;
         o_msb           <= '0;
         o_isb           <= '0;
         o_lsb           <= '0;
         o_seed          <= '0;
         o_sel_order     <= '0;
         o_mash_bit      <= '0;
         o_sel_frac      <= 1'b0;
      end else begin
         o_ready         <= ready_n;
         o_busy          <= (state_n != ST_IDLE);
         o_done          <= (state == ST_DONE);
         o_mashreseten   <= (state == ST_RESET);
         o_phaseadjusten <= (state == ST_PHASE);
         o_phaseadd      <= (state == ST_PHASE) ? shadow.phaseadd : '0;
         // MASH config changes only on reseed requests, as RESET is entered
         if (start && start_cfg.reseed) begin
            o_seed      <= start_cfg.seed;
            o_sel_order <= start_cfg.sel_order;
            o_mash_bit  <= start_cfg.mash_bit;
            o_sel_frac  <= start_cfg.sel_frac;
         end
         // All four frequency words move together on APPLY exit
         if (state == ST_APPLY) begin
            o_int <= shadow.int_word;
            o_msb <= shadow.msb;
            o_isb <= shadow.isb;
            o_lsb <= shadow.lsb;
         end
      end
   end

   // MASH config fields are taken from start_cfg at launch, so the shadow copies are not read
   logic unused_shadow_c;
   assign unused_shadow_c = ^{shadow.seed, shadow.sel_order, shadow.mash_bit,
                              shadow.sel_frac, shadow.reseed};

   ncsp_seq_cfg_reg u_shadow (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (start),
      .i_d     (start_cfg),
      .o_q     (shadow)
   );

`ifdef NCSP_SEQ_QUEUE_EN
   ncsp_seq_cfg_reg u_pend (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (pend_load),
      .i_d     (req),
      .o_q     (pend)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) pend_full <= 1'b0;
      else          pend_full <= pend_full_n;
   end
`endif

endmodule
